// File: rtl/voter_pkg.sv
// Shared types and encodings for the four-voter ballot controller.
// Imported by the controller, its tally sub-module and the bus interface users.
package voter_pkg;

    localparam int unsigned N_VOTERS = 4;

    // Every voter has a latched ballot; closes the collection window early.
    localparam logic [N_VOTERS-1:0] VOTERS_ALL = 4'b1111;

    localparam logic [2:0] RES_NONE     = 3'b000;
    localparam logic [2:0] RES_MINORITY = 3'b001;
    localparam logic [2:0] RES_TIE      = 3'b010;
    localparam logic [2:0] RES_MAJORITY = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        TALLY   = 2'd2,
        REPORT  = 2'd3
    } state_e;

    // Number of yes ballots in a 4-bit ballot word (0..4).
    function automatic logic [2:0] count_yes(input logic [N_VOTERS-1:0] ballot);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < int'(N_VOTERS); i++) begin
            n = n + {2'b00, ballot[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/voter_if.sv
// Ballot bus between a session driver (master) and the voter controller (slave).
interface voter_if;
    import voter_pkg::*;

    logic                start;
    logic [N_VOTERS-1:0] vote_en;
    logic [N_VOTERS-1:0] vote_val;
    logic                busy;
    logic [N_VOTERS-1:0] voted;
    logic [2:0]          result;
    logic                done;
    logic                timed_out;

    modport master (
        output start, vote_en, vote_val,
        input  busy, voted, result, done, timed_out
    );

    modport slave (
        input  start, vote_en, vote_val,
        output busy, voted, result, done, timed_out
    );

endinterface

// File: rtl/voter_tally.sv
// Maps a 4-bit ballot word to the one-hot outcome: 0-1 yes, 2 yes (tie), 3-4 yes.
module voter_tally
    import voter_pkg::*;
(
    input  logic [N_VOTERS-1:0] ballot,
    output logic [2:0]          onehot
);

    logic [2:0] yes_cnt;

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        yes_cnt = count_yes(ballot);
        onehot  = RES_MINORITY;
        if (yes_cnt >= 3'd3) begin
            onehot = RES_MAJORITY;
        end else if (yes_cnt == 3'd2) begin
            onehot = RES_TIE;
        end
    end

endmodule

// File: rtl/voter_ctrl.sv
// Ballot session controller: opens a window on start, latches first ballots per voter,
// closes on all-voted or timeout, then tallies and pulses done for one cycle.
module voter_ctrl
    import voter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic   clk,
    input  logic   rst,
    voter_if.slave bus
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_e              state, state_nxt;
    logic [N_VOTERS-1:0] voted, voted_nxt;
    logic [N_VOTERS-1:0] ballot, ballot_nxt;
    logic [N_VOTERS-1:0] fresh;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic [2:0]          result, result_nxt;
    logic [2:0]          tally_onehot;
    logic                timed_out, timed_out_nxt;

    // Non-voters keep a 0 ballot bit, so they count as no.
    voter_tally u_tally (
        .ballot (ballot),
        .onehot (tally_onehot)
    );

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voted     <= '0;
            ballot    <= '0;
            timer     <= '0;
            result    <= RES_NONE;
            timed_out <= 1'b0;
        end else begin
            voted     <= voted_nxt;
            ballot    <= ballot_nxt;
            timer     <= timer_nxt;
            result    <= result_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        voted_nxt     = voted;
        ballot_nxt    = ballot;
        timer_nxt     = timer;
        result_nxt    = result;
        timed_out_nxt = timed_out;
        fresh         = '0;

        unique case (state)
            IDLE: begin
                // vote_en is deliberately not looked at here, even alongside start.
                if (bus.start) begin
                    voted_nxt  = '0;
                    ballot_nxt = '0;
                    timer_nxt  = '0;
                    state_nxt  = COLLECT;
                end
            end

            COLLECT: begin
                // Only first ballots land; re-votes from already-voted voters are masked off.
                fresh      = bus.vote_en & ~voted;
                voted_nxt  = voted | fresh;
                ballot_nxt = (ballot & ~fresh) | (bus.vote_val & fresh);
                timer_nxt  = timer + TIMER_W'(1);
                if (voted_nxt == VOTERS_ALL || timer == TIMER_LAST) begin
                    state_nxt = TALLY;
                end
            end

            TALLY: begin
                result_nxt    = tally_onehot;
                timed_out_nxt = (voted != VOTERS_ALL);
                state_nxt     = REPORT;
            end

            REPORT: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == REPORT);
    assign bus.voted     = voted;
    assign bus.result    = result;
    assign bus.timed_out = timed_out;

endmodule

// File: tb/tb_voter_ctrl.sv
// Self-checking bench for voter_ctrl: directed sessions with literal expectations,
// then random traffic compared every cycle against a session-level reference model.
module tb_voter_ctrl;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    voter_if bus ();

    voter_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is "idle", "open" (ballots accepted), "closing"
    // (one cycle to count) or "reporting" (done visible). Outcome from a plain yes count.
    localparam int S_IDLE = 0, S_OPEN = 1, S_CLOSING = 2, S_REPORTING = 3;
    int         m_session = S_IDLE;
    int         m_elapsed = 0;
    logic [3:0] m_voted   = '0;
    logic [3:0] m_yes     = '0;
    logic [2:0] m_result  = '0;
    logic       m_to      = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_session = S_IDLE;
            m_elapsed = 0;
            m_voted   = '0;
            m_yes     = '0;
            m_result  = '0;
            m_to      = 1'b0;
        end else begin
            case (m_session)
                S_IDLE: if (bus.start) begin
                    m_session = S_OPEN;
                    m_elapsed = 0;
                    m_voted   = '0;
                    m_yes     = '0;
                end
                S_OPEN: begin
                    for (int i = 0; i < 4; i++) begin
                        if (bus.vote_en[i] && !m_voted[i]) begin
                            m_voted[i] = 1'b1;
                            m_yes[i]   = bus.vote_val[i];
                        end
                    end
                    if (m_voted == 4'hf || m_elapsed == TO - 1) m_session = S_CLOSING;
                    m_elapsed++;
                end
                S_CLOSING: begin
                    int n;
                    n = 0;
                    for (int i = 0; i < 4; i++) n += int'(m_yes[i]);
                    m_result  = (n >= 3) ? 3'b100 : (n == 2) ? 3'b010 : 3'b001;
                    m_to      = (m_voted != 4'hf);
                    m_session = S_REPORTING;
                end
                default: m_session = S_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("busy",      {31'd0, bus.busy},      {31'd0, m_session != S_IDLE});
            check("done",      {31'd0, bus.done},      {31'd0, m_session == S_REPORTING});
            check("voted",     {28'd0, bus.voted},     {28'd0, m_voted});
            check("result",    {29'd0, bus.result},    {29'd0, m_result});
            check("timed_out", {31'd0, bus.timed_out}, {31'd0, m_to});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.vote_en  = '0;
        bus.vote_val = '0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check({name, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        model_on = 1'b1;

        check("rst_busy",   {31'd0, bus.busy},      32'd0);
        check("rst_done",   {31'd0, bus.done},      32'd0);
        check("rst_voted",  {28'd0, bus.voted},     32'd0);
        check("rst_result", {29'd0, bus.result},    32'd0);
        check("rst_to",     {31'd0, bus.timed_out}, 32'd0);

        // All four vote at once: 3 yes -> majority, done two cycles after the votes.
        bus.start = 1'b1; tick();
        bus.start = 1'b0; bus.vote_en = 4'b1111; bus.vote_val = 4'b1011; tick();
        idle_inputs();
        check("a_done_in_tally", {31'd0, bus.done}, 32'd0);
        tick();
        check("a_done",   {31'd0, bus.done},      32'd1);
        check("a_result", {29'd0, bus.result},    32'b100);
        check("a_to",     {31'd0, bus.timed_out}, 32'd0);
        tick();
        check("a_done_one_cycle", {31'd0, bus.done}, 32'd0);

        // Two yes then silence: timeout, tie, done at collect cycle 17.
        bus.start = 1'b1; tick();
        bus.start = 1'b0; bus.vote_en = 4'b0001; bus.vote_val = 4'b0001; tick();
        bus.vote_en = 4'b0010; bus.vote_val = 4'b0010; tick();
        idle_inputs();
        repeat (14) tick();
        check("b_done_early", {31'd0, bus.done}, 32'd0);
        tick();
        check("b_done",   {31'd0, bus.done},      32'd1);
        check("b_result", {29'd0, bus.result},    32'b010);
        check("b_to",     {31'd0, bus.timed_out}, 32'd1);
        check("b_voted",  {28'd0, bus.voted},     32'b0011);
        tick();

        // Voter 2 re-votes yes after a no: ignored, all-no minority.
        bus.start = 1'b1; tick();
        bus.start = 1'b0; bus.vote_en = 4'b0100; bus.vote_val = 4'b0000; tick();
        bus.vote_en = 4'b0011; bus.vote_val = 4'b0000; tick();
        bus.vote_en = 4'b0100; bus.vote_val = 4'b0100; tick();
        bus.vote_en = 4'b1000; bus.vote_val = 4'b0000; tick();
        idle_inputs();
        wait_done(5, "c");
        check("c_result", {29'd0, bus.result},    32'b001);
        check("c_voted",  {28'd0, bus.voted},     32'b1111);
        check("c_to",     {31'd0, bus.timed_out}, 32'd0);
        tick();

        // Reset in mid-collect discards the session.
        bus.start = 1'b1; tick();
        bus.start = 1'b0; bus.vote_en = 4'b0101; bus.vote_val = 4'b0101; tick();
        idle_inputs();
        check("d_voted_before", {28'd0, bus.voted}, 32'b0101);
        rst = 1'b1; bus.start = 1'b1; bus.vote_en = 4'b1111; tick();
        rst = 1'b0; idle_inputs();
        check("d_busy",   {31'd0, bus.busy},   32'd0);
        check("d_voted",  {28'd0, bus.voted},  32'd0);
        check("d_result", {29'd0, bus.result}, 32'd0);
        pulses = 0;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        check("d_no_done", pulses, 32'd0);

        // Votes alongside start are ignored; session then times out with nobody voted.
        bus.start = 1'b1; bus.vote_en = 4'b1111; bus.vote_val = 4'b1111; tick();
        idle_inputs();
        check("e_voted", {28'd0, bus.voted}, 32'd0);
        check("e_busy",  {31'd0, bus.busy},  32'd1);
        wait_done(TO + 4, "e");
        check("e_result", {29'd0, bus.result},    32'b001);
        check("e_to",     {31'd0, bus.timed_out}, 32'd1);
        tick();

        // Fourth ballot arrives in the last timer cycle: counted, no timeout.
        bus.start = 1'b1; tick();
        bus.start = 1'b0; bus.vote_en = 4'b0111; bus.vote_val = 4'b0111; tick();
        idle_inputs();
        repeat (14) tick();
        bus.vote_en = 4'b1000; bus.vote_val = 4'b1000; tick();
        idle_inputs();
        tick();
        check("f_done",   {31'd0, bus.done},      32'd1);
        check("f_result", {29'd0, bus.result},    32'b100);
        check("f_to",     {31'd0, bus.timed_out}, 32'd0);
        check("f_voted",  {28'd0, bus.voted},     32'b1111);
        tick();

        // Random traffic, including starts while busy and occasional resets.
        repeat (600) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.vote_en  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            bus.vote_val = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (TO + 4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voter_ctrl.md
VOTER_CTRL -- requirements
Module: voter_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the ballot window length in clock cycles; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: opens a ballot; sampled only in IDLE.
REQ-005 SHALL have port vote_en, input, 4 bits: per-voter vote strobe, bit i = voter i.
REQ-006 SHALL have port vote_val, input, 4 bits: per-voter ballot, 1 = yes, qualified by vote_en[i].
REQ-007 SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-008 SHALL have port voted, output, 4 bits: voters whose ballot is latched in the current or last session.
REQ-009 SHALL have port result, output, 3 bits: one-hot outcome, [0] = 0-1 yes, [1] = 2 yes (tie), [2] = 3-4 yes (majority).
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when result updates.
REQ-011 SHALL have port timed_out, output, 1 bit: last session closed by timeout with fewer than 4 ballots.

Function
REQ-012 SHALL implement states IDLE, COLLECT, TALLY, REPORT.
REQ-013 IDLE: start=1 SHALL clear voted, the ballot register and the timer, then enter COLLECT the next cycle; result and timed_out hold until TALLY.
REQ-014 IDLE: vote_en SHALL be ignored, including in the cycle start is asserted.
REQ-015 COLLECT: for each i with vote_en[i]=1 and voted[i]=0, SHALL latch vote_val[i] and set voted[i].
REQ-016 COLLECT: re-votes (vote_en[i]=1 with voted[i]=1) SHALL be ignored; the first ballot is final.
REQ-017 COLLECT: the timer SHALL start at 0 on entry and increment each cycle; width is the minimum needed to count TIMEOUT_CYCLES-1.
REQ-018 COLLECT SHALL go to TALLY when the updated voted value equals 4'b1111, or when the timer equals TIMEOUT_CYCLES-1.
REQ-019 Ballots arriving in the closing COLLECT cycle SHALL be latched and counted.
REQ-020 Voters that did not vote SHALL count as no.
REQ-021 TALLY SHALL count yes ballots (0..4) and register result: 0-1 gives 3'b001, 2 gives 3'b010, 3-4 gives 3'b100.
REQ-022 TALLY SHALL set timed_out = (voted != 4'b1111) and then enter REPORT.
REQ-023 REPORT SHALL assert done for exactly that cycle and return to IDLE.
REQ-024 Latency: if all ballots are in by COLLECT cycle k, done SHALL be high at cycle k+2.
REQ-025 start SHALL be ignored in COLLECT, TALLY and REPORT; no queuing.
REQ-026 result SHALL always be one-hot after the first TALLY; it SHALL never be 3'b000 except from reset until the first TALLY.

Reset
REQ-027 rst=1 SHALL, at the next edge and from any state, force: state IDLE, busy 0, done 0, voted 4'b0000, result 3'b000, timed_out 0, timer 0, ballot register 0.
REQ-028 rst SHALL take priority over start and vote_en in the same cycle.
REQ-029 An in-progress session interrupted by rst SHALL be discarded, with no done pulse.

Structure
REQ-030 A shared package voter_pkg SHALL hold the state enum and the result encodings RES_MINORITY=3'b001, RES_TIE=3'b010 and RES_MAJORITY=3'b100.
REQ-031 The combinational count-to-one-hot mapping SHALL be a sub-module voter_tally, with 4-bit ballot input and 3-bit one-hot output, instantiated once.

Verification
REQ-032 start; next cycle vote_en=4'b1111 and vote_val=4'b1011 -> TALLY the following cycle, done 2 cycles after the votes, result=3'b100, timed_out=0.
REQ-033 start; voter0 votes yes then voter1 votes yes; voters 2-3 silent; TIMEOUT_CYCLES=16 -> done at COLLECT cycle 17, result=3'b010, timed_out=1, voted=4'b0011.
REQ-034 Voter2 votes no, later re-votes yes, others vote no -> result=3'b001; the re-vote is ignored.
REQ-035 rst asserted in mid-COLLECT with voted=4'b0101 -> next cycle IDLE, voted=0, result=0, no done pulse.
REQ-036 start together with vote_en=4'b1111 in IDLE -> those votes are ignored, voted=0 on COLLECT entry.
REQ-037 Last ballot arrives in the timer=TIMEOUT_CYCLES-1 cycle -> it is counted and timed_out=0 if it is the 4th ballot.
